// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// State encodings and default bus widths.
package dmem_arbiter_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_WAIT  = 2'b01,
      ARB_STEAL = 2'b10
   } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
// o_tc flags the last denied cycle before a steal.
module dmem_arbiter_sat_counter #(
   parameter int MAX = 8
) (
   input  logic i_clk,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] TC_V  = W'(MAX - 1);
   localparam logic [W-1:0] SAT_V = W'(MAX);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != SAT_V)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tc = (r_cnt == TC_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU has priority, debug master
// is granted on idle cycles or by stealing after MAX_WAIT denials.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cpu_re,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_hold,
   input  logic              i_dbg_halt,
   input  logic              i_dbg_req,
   input  logic              i_dbg_we,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   input  logic [DATA_W-1:0] i_dbg_wdata,
   output logic              o_dbg_gnt,
   output logic              o_dbg_rvalid,
   output logic [DATA_W-1:0] o_dbg_rdata,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   output logic              o_ram_we,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   arb_state_t        r_state;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   logic w_cpu_act;
   logic w_steal;
   logic w_hold;
   logic w_gnt;
   logic w_deny;
   logic w_tc;
   logic w_inc;
   logic w_clr;
   logic w_rd_gnt;

   assign w_cpu_act = i_cpu_re | i_cpu_we;
   assign w_steal   = (r_state == ARB_STEAL);
   assign w_hold    = i_dbg_halt | w_steal;
   assign w_gnt     = i_dbg_req & (w_hold | ~w_cpu_act);
   assign w_deny    = i_dbg_req & ~w_gnt;
   assign w_rd_gnt  = w_gnt & ~i_dbg_we;

   // Count only denials that do not yet trigger a steal; all else clears.
   assign w_inc = ~i_dbg_halt & w_deny & ~w_tc
                & ((r_state == ARB_IDLE) | (r_state == ARB_WAIT));
   assign w_clr = ~i_reset | ~w_inc;

   dmem_arbiter_sat_counter #(
      .MAX (MAX_WAIT)
   ) u_wait_cnt (
      .i_clk (i_clk),
      .i_clr (w_clr),
      .i_inc (w_inc),
      .o_tc  (w_tc)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state  <= ARB_IDLE;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_rd_gnt;
         if (w_rd_gnt) begin
            r_rdata <= i_ram_rdata;
         end
         if (i_dbg_halt) begin
            r_state <= ARB_IDLE;
         end else begin
            unique case (r_state)
               ARB_IDLE: begin
                  if (w_deny) begin
                     r_state <= w_tc ? ARB_STEAL : ARB_WAIT;
                  end
               end
               ARB_WAIT: begin
                  if (!i_dbg_req || w_gnt) begin
                     r_state <= ARB_IDLE;
                  end else if (w_tc) begin
                     r_state <= ARB_STEAL;
                  end
               end
               ARB_STEAL: r_state <= ARB_IDLE;
               default:   r_state <= ARB_IDLE;
            endcase
         end
      end
   end

   assign o_cpu_rdata  = i_ram_rdata;
   assign o_cpu_hold   = w_hold;
   assign o_dbg_gnt    = w_gnt;
   assign o_dbg_rvalid = r_rvalid;
   assign o_dbg_rdata  = r_rdata;
   assign o_ram_addr   = w_gnt ? i_dbg_addr  : i_cpu_addr;
   assign o_ram_wdata  = w_gnt ? i_dbg_wdata : i_cpu_wdata;
   assign o_ram_we     = i_reset
                       & (w_gnt ? i_dbg_we : (i_cpu_we & ~w_hold));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word RAM model.
// A second MAX_WAIT=1 instance covers the immediate-steal case.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_re;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_hold;
   logic        dbg_halt;
   logic        dbg_req;
   logic        dbg_we;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_gnt;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_we;
   logic [31:0] ram_rdata;

   logic [31:0] u1_cpu_rdata;
   logic        u1_hold;
   logic        u1_gnt;
   logic        u1_rvalid;
   logic [31:0] u1_rdata;
   logic [31:0] u1_ram_addr;
   logic [31:0] u1_ram_wdata;
   logic        u1_ram_we;

   logic [31:0] mem [256];

   int n_chk;
   int n_err;

   dmem_arbiter #(.MAX_WAIT(8)) dut (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_cpu_re     (cpu_re),
      .i_cpu_we     (cpu_we),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_rdata  (cpu_rdata),
      .o_cpu_hold   (cpu_hold),
      .i_dbg_halt   (dbg_halt),
      .i_dbg_req    (dbg_req),
      .i_dbg_we     (dbg_we),
      .i_dbg_addr   (dbg_addr),
      .i_dbg_wdata  (dbg_wdata),
      .o_dbg_gnt    (dbg_gnt),
      .o_dbg_rvalid (dbg_rvalid),
      .o_dbg_rdata  (dbg_rdata),
      .o_ram_addr   (ram_addr),
      .o_ram_wdata  (ram_wdata),
      .o_ram_we     (ram_we),
      .i_ram_rdata  (ram_rdata)
   );

   dmem_arbiter #(.MAX_WAIT(1)) u1 (
      .i_clk        (clk),
      .i_reset      (rst_n),
      .i_cpu_re     (cpu_re),
      .i_cpu_we     (cpu_we),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .o_cpu_rdata  (u1_cpu_rdata),
      .o_cpu_hold   (u1_hold),
      .i_dbg_halt   (dbg_halt),
      .i_dbg_req    (dbg_req),
      .i_dbg_we     (dbg_we),
      .i_dbg_addr   (dbg_addr),
      .i_dbg_wdata  (dbg_wdata),
      .o_dbg_gnt    (u1_gnt),
      .o_dbg_rvalid (u1_rvalid),
      .o_dbg_rdata  (u1_rdata),
      .o_ram_addr   (u1_ram_addr),
      .o_ram_wdata  (u1_ram_wdata),
      .o_ram_we     (u1_ram_we),
      .i_ram_rdata  (32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[7:0]];

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr[7:0]] = ram_wdata;
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + i;

      // 1: reset with a pending debug write
      rst_n = 0; cpu_re = 0; cpu_we = 0;
      cpu_addr = 0; cpu_wdata = 0; dbg_halt = 0;
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h20; dbg_wdata = 32'h55;
      #1;
      chk("rst_we0", 32'(ram_we), 0);
      tick();
      chk("rst_we1", 32'(ram_we), 0);
      chk("rst_rv1", 32'(dbg_rvalid), 0);
      tick();
      chk("rst_rv2", 32'(dbg_rvalid), 0);
      chk("rst_rd", dbg_rdata, 0);
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_mem", mem[8'h20], 0);
      rst_n = 1; dbg_req = 0;
      #1;
      chk("idle_gnt", 32'(dbg_gnt), 0);

      // 2: idle-cycle debug read
      tick();
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
      #1;
      chk("rd_gnt", 32'(dbg_gnt), 1);
      chk("rd_addr", ram_addr, 32'h10);
      chk("cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      tick();
      dbg_req = 0;
      chk("rd_rv", 32'(dbg_rvalid), 1);
      chk("rd_data", dbg_rdata, 32'hDEADBEEF);
      tick();
      chk("rd_rv_off", 32'(dbg_rvalid), 0);

      // 3: CPU load every cycle, debug write steals on cycle 9
      cpu_re = 1; cpu_addr = 32'h30;
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h40; dbg_wdata = 32'hCAFE0001;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("st_deny", 32'(dbg_gnt), 0);
         chk("st_hold0", 32'(cpu_hold), 0);
         if (i == 0) chk("m1_deny", 32'(u1_gnt), 0);
         if (i == 1) chk("m1_gnt", 32'(u1_gnt), 1);
         if (i == 1) chk("m1_hold", 32'(u1_hold), 1);
         tick();
      end
      #1;
      chk("st_hold", 32'(cpu_hold), 1);
      chk("st_gnt", 32'(dbg_gnt), 1);
      chk("st_we", 32'(ram_we), 1);
      chk("st_addr", ram_addr, 32'h40);
      chk("st_wd", ram_wdata, 32'hCAFE0001);
      tick();
      dbg_req = 0;
      #1;
      chk("st_rel", 32'(cpu_hold), 0);
      chk("st_cpu", ram_addr, 32'h30);
      chk("st_mem", mem[8'h40], 32'hCAFE0001);
      tick();

      // 4: CPU store suppressed in the steal cycle
      dbg_req = 1; dbg_addr = 32'h60; dbg_wdata = 32'h22222222;
      for (int i = 0; i < 8; i++) tick();
      cpu_re = 0; cpu_we = 1;
      cpu_addr = 32'h50; cpu_wdata = 32'h11111111;
      #1;
      chk("sw_hold", 32'(cpu_hold), 1);
      chk("sw_addr", ram_addr, 32'h60);
      tick();
      cpu_we = 0; dbg_req = 0;
      chk("sw_cpu", mem[8'h50], 0);
      chk("sw_dbg", mem[8'h60], 32'h22222222);
      tick();

      // 5: halted CPU, four back-to-back reads
      dbg_halt = 1; cpu_re = 1;
      dbg_req = 1; dbg_we = 0;
      for (int k = 0; k < 4; k++) begin
         dbg_addr = k;
         #1;
         chk("h_gnt", 32'(dbg_gnt), 1);
         chk("h_hold", 32'(cpu_hold), 1);
         if (k > 0) begin
            chk("h_rv", 32'(dbg_rvalid), 1);
            chk("h_rd", dbg_rdata, 32'hA0 + k - 1);
         end
         tick();
      end
      dbg_req = 0;
      #1;
      chk("h_rv3", 32'(dbg_rvalid), 1);
      chk("h_rd3", dbg_rdata, 32'hA3);
      dbg_halt = 0;
      #1;
      chk("h_off", 32'(cpu_hold), 0);
      tick();
      chk("h_rv_off", 32'(dbg_rvalid), 0);

      // 6a: reset on the read-grant edge
      cpu_re = 0;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
      rst_n = 0;
      tick();
      chk("r6_rv", 32'(dbg_rvalid), 0);
      chk("r6_rd", dbg_rdata, 0);
      rst_n = 1; dbg_req = 0;
      tick();
      chk("r6_rv2", 32'(dbg_rvalid), 0);

      // 6b: reset in WAIT at count 5 restarts the count
      cpu_re = 1; cpu_addr = 32'h30;
      dbg_req = 1; dbg_we = 1;
      dbg_addr = 32'h70; dbg_wdata = 32'h77;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 0; cpu_re = 0; cpu_we = 1; cpu_wdata = 32'h99;
      #1;
      chk("r6_we", 32'(ram_we), 0);
      tick();
      chk("r6_mem", mem[8'h30], 0);
      rst_n = 1; cpu_we = 0; cpu_re = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("r6_deny", 32'(dbg_gnt), 0);
         tick();
      end
      #1;
      chk("r6_gnt", 32'(dbg_gnt), 1);
      chk("r6_hold", 32'(cpu_hold), 1);
      tick();
      dbg_req = 0;
      chk("r6_wr", mem[8'h70], 32'h77);
      #1;
      chk("r6_rel", 32'(cpu_hold), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
